// File: rtl/style_record_unpack_if.sv
// Record-stream bus for style_record_unpack.
//   in_*   : 32-bit word stream (valid/ready) from the upstream feeder
//   out_*  : unpacked record head (valid/ready) toward the display comparator
interface style_record_unpack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  logic        out_valid;
  logic        out_ready;
  logic        element_valid;
  logic        is_svg_element;
  logic [5:0]  style_type;
  logic [4:0]  display;
  logic [5:0]  class_type;
  logic [15:0] elem_id;

  // master: word producer and record consumer (testbench / neighbours)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, element_valid, is_svg_element,
           style_type, display, class_type, elem_id
  );

  // slave: the unpacker itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, element_valid, is_svg_element,
           style_type, display, class_type, elem_id
  );
endinterface

// File: rtl/style_record_unpack.sv
// Unpacks two-word element style records (header + body) into comparator
// fields, buffers them in a FIFO_DEPTH-entry FIFO, and holds the programmable
// display enum constants.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus             : word stream in / record stream out (slave modport)
//   cfg_we/cfg_data : load {nopseudo, none, inline, block}
//   NOPSEUDO..BLOCK : registered enum constants
//   rec_count       : records pushed since reset (wrapping)
//   err_count       : rejected header words (saturating)
module style_record_unpack #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  style_record_unpack_if.slave bus,
  input  logic                 cfg_we,
  input  logic [20:0]          cfg_data,
  output logic [5:0]           NOPSEUDO,
  output logic [4:0]           NONE,
  output logic [4:0]           INLINE,
  output logic [4:0]           BLOCK,
  output logic [15:0]          rec_count,
  output logic [7:0]           err_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic       element_valid;
    logic       is_svg_element;
    logic [5:0] style_type;
    logic [4:0] display;
    logic [5:0] class_type;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [15:0] elem_id;
  } rec_t;

  typedef enum logic {S_HDR, S_BODY} state_e;

  state_e          state_q, state_d;
  hdr_t            hdr_q, hdr_d;
  rec_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            full_c, push_c, pop_c, bad_c, in_xfer_c;
  rec_t            head_c;
  logic            unused_c;

  assign unused_c = ^bus.in_data[8:0];

  // in_ready depends only on FSM state and FIFO fullness
  assign full_c       = (cnt_q == CW'(FIFO_DEPTH));
  assign bus.in_ready = (state_q == S_HDR) || !full_c;
  assign in_xfer_c    = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (cnt_q != '0);
  assign pop_c        = bus.out_valid && bus.out_ready;

  // Record framing: header latches fields, body completes and pushes
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    push_c  = 1'b0;
    bad_c   = 1'b0;
    case (state_q)
      S_HDR: begin
        if (in_xfer_c) begin
          if (bus.in_data[31:28] == 4'hA) begin
            hdr_d   = hdr_t'(bus.in_data[27:9]);
            state_d = S_BODY;
          end else begin
            bad_c = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (in_xfer_c) begin
          push_c  = 1'b1;
          state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Control state, FIFO pointers, counters and constants
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_HDR;
      hdr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rec_count <= '0;
      err_count <= '0;
      NOPSEUDO  <= 6'd0;
      NONE      <= 5'd16;
      INLINE    <= 5'd0;
      BLOCK     <= 5'd1;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      if (push_c) begin
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        rec_count <= rec_count + 16'd1;
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_c) - CW'(pop_c);
      if (bad_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (cfg_we) begin
        NOPSEUDO <= cfg_data[20:15];
        NONE     <= cfg_data[14:10];
        INLINE   <= cfg_data[9:5];
        BLOCK    <= cfg_data[4:0];
      end
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (rst_n && push_c) mem[wr_ptr_q] <= rec_t'({hdr_q, bus.in_data[15:0]});
  end

  assign head_c             = mem[rd_ptr_q];
  assign bus.element_valid  = head_c.hdr.element_valid;
  assign bus.is_svg_element = head_c.hdr.is_svg_element;
  assign bus.style_type     = head_c.hdr.style_type;
  assign bus.display        = head_c.hdr.display;
  assign bus.class_type     = head_c.hdr.class_type;
  assign bus.elem_id        = head_c.elem_id;

endmodule

// File: tb/tb_style_record_unpack.sv
// Self-checking bench for style_record_unpack: table-driven records, directed
// multi-cycle sequences and randomized traffic against a stream-level model.
module tb_style_record_unpack;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [20:0] cfg_data;
  logic [5:0]  NOPSEUDO;
  logic [4:0]  NONE, INLINE, BLOCK;
  logic [15:0] rec_count;
  logic [7:0]  err_count;

  style_record_unpack_if bus();

  style_record_unpack #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .NOPSEUDO(NOPSEUDO), .NONE(NONE), .INLINE(INLINE), .BLOCK(BLOCK),
    .rec_count(rec_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Stream-level model: expected records in delivery order
  logic [34:0] exp_q[$];
  bit          m_body;
  logic [18:0] m_pend;
  int          m_rec, m_err;
  logic [20:0] m_cfg;
  localparam logic [20:0] CFG_RST = {6'd0, 5'd16, 5'd0, 5'd1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [34:0] head_bits();
    return {bus.element_valid, bus.is_svg_element, bus.style_type,
            bus.display, bus.class_type, bus.elem_id};
  endfunction

  // Check state before the edge, advance one cycle, update the model
  task automatic tick();
    bit          rdy_e, acc, pop, we;
    logic [31:0] w;
    logic [20:0] cd;
    rdy_e = !m_body || (exp_q.size() < DEPTH);
    if (rst_n) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(rdy_e));
      chk("rec_count", 64'(rec_count), 64'(m_rec[15:0]));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("cfg", 64'({NOPSEUDO, NONE, INLINE, BLOCK}), 64'(m_cfg));
      if (exp_q.size() != 0) chk("head", 64'(head_bits()), 64'(exp_q[0]));
    end
    acc = bus.in_valid && rdy_e;
    pop = bus.out_ready && (exp_q.size() != 0);
    w   = bus.in_data;
    we  = cfg_we;
    cd  = cfg_data;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete(); m_body = 0; m_pend = '0; m_rec = 0; m_err = 0; m_cfg = CFG_RST;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (m_body) begin
          exp_q.push_back({m_pend, w[15:0]});
          m_rec++;
          m_body = 0;
        end else if (w[31:28] == 4'hA) begin
          m_pend = w[27:9];
          m_body = 1;
        end else if (m_err < 255) m_err++;
      end
      if (we) m_cfg = cd;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; cfg_we = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    bus.in_data = w; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (!bus.in_ready) chk("send_timeout", 64'(0), 64'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while (bus.out_valid && n < 50) begin tick(); n++; end
    chk("drain_empty", 64'(bus.out_valid), 64'(0));
    chk("model_empty", 64'(exp_q.size()), 64'(0));
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] body;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bus.in_data = '0; cfg_data = '0;
    m_cfg = CFG_RST;
    vecs[0] = '{32'hAC00_8A00, 32'h0000_1234, {1'b1, 1'b1, 6'h00, 5'h01, 6'h05, 16'h1234}};
    vecs[1] = '{32'hA6A9_FFFF, 32'hFFFF_BEEF, {1'b0, 1'b1, 6'h2A, 5'h13, 6'h3F, 16'hBEEF}};
    vecs[2] = '{32'hABF0_0000, 32'h1234_0000, {1'b1, 1'b0, 6'h3F, 5'h00, 6'h00, 16'h0000}};
    vecs[3] = '{32'hA00F_AA00, 32'h0000_5A5A, {1'b0, 1'b0, 6'h00, 5'h1F, 6'h15, 16'h5A5A}};

    // Reset then idle
    do_reset();
    chk("rst_cfg", 64'({NOPSEUDO, NONE, INLINE, BLOCK}), 64'({6'd0, 5'd16, 5'd0, 5'd1}));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_counts", 64'({rec_count, err_count}), 64'(0));

    // Table-driven single records
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].hdr);
      send(vecs[i].body);
      chk("vec_valid", 64'(bus.out_valid), 64'(1));
      chk("vec_fields", 64'(head_bits()), 64'(vecs[i].exp));
      chk("vec_rec", 64'(rec_count), 64'(i + 1));
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    end

    // Backpressure: 4 buffered, fifth body stalls, then release
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(32'hA000_0000 | 32'(i << 9)); send(32'(16'h100 + i));
    end
    send(32'hA800_0000);
    chk("bp_stall", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    send(32'h0000_0104);
    send(32'hAC00_0000); send(32'h0000_0105);
    drain();
    chk("bp_rec", 64'(rec_count), 64'(6));

    // Bad magic saturation, then a valid record
    do_reset();
    for (int i = 0; i < 300; i++) send(32'h3000_0000 | 32'(i));
    chk("err_sat", 64'(err_count), 64'(255));
    send(vecs[1].hdr); send(vecs[1].body);
    chk("err_rec", 64'(head_bits()), 64'(vecs[1].exp));
    drain();

    // Simultaneous push/pop at occupancy 2
    do_reset();
    send(vecs[0].hdr); send(vecs[0].body);
    send(vecs[2].hdr); send(vecs[2].body);
    send(vecs[3].hdr);
    bus.out_ready = 1'b1;
    send(vecs[3].body);
    bus.out_ready = 1'b0;
    chk("pp_head", 64'(head_bits()), 64'(vecs[2].exp));
    begin
      int pops = 0;
      bus.out_ready = 1'b1;
      while (bus.out_valid && pops < 10) begin tick(); pops++; end
      bus.out_ready = 1'b0;
      chk("pp_occupancy", 64'(pops), 64'(2));
    end

    // Reset mid-record, then normal record and config load
    do_reset();
    send(vecs[0].hdr);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_in_ready", 64'(bus.in_ready), 64'(1));
    send(vecs[3].hdr); send(vecs[3].body);
    chk("mid_rec", 64'(head_bits()), 64'(vecs[3].exp));
    drain();
    cfg_data = 21'h1F_FFFF; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
    chk("cfg_load", 64'({NOPSEUDO, NONE, INLINE, BLOCK}), 64'({6'd63, 5'd31, 5'd31, 5'd31}));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:28] = 4'hA;
      bus.in_data   = w;
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      cfg_we        = ($urandom_range(0, 49) == 0);
      cfg_data      = 21'($urandom);
      tick();
    end
    cfg_we = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
